// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush.
// Flush wins over push; the head is forced to zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_c,
  output logic [CW-1:0] count,
  output logic         full_c,
  output logic         empty_c
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en_c;
  logic          pop_en_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign pop_en_c  = pop && !empty_c;
  assign push_en_c = push && (!full_c || pop_en_c);
  assign count     = count_q;
  assign head_c    = empty_c ? '0 : mem_q[rd_ptr_q];

  // Pointer, count and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en_c) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_en_c) - CW'(pop_en_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, fetch/halt FSM and redirect handling,
// feeding a prefetch buffer that presents words to decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] rom_address,
  input  logic [XLEN-1:0] rom_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            empty_c;
  logic [CW-1:0]   count_c;
  fetch_entry_t    head_c;
  fetch_entry_t    push_entry_c;
  logic            unused_ok;

  assign rom_address  = pc_q;
  assign instr_valid  = !empty_c;
  assign instr        = head_c.instr;
  assign instr_pc     = head_c.pc;
  assign pop_c        = instr_valid && instr_ready;
  assign push_entry_c = '{pc: pc_q, instr: rom_instruction};
  assign unused_ok    = ^{redirect_target[1:0], count_c};

  // Next state, push enable and next PC; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_c  = 1'b0;
    case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (!redirect_valid && (!full_c || pop_c)) begin
          push_c = 1'b1;
        end
      end
      HALTED: begin
        if (!halt) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid) begin
      pc_d = word_align(redirect_target);
    end else if (push_c) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .head_c    (head_c),
    .count     (count_c),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: owns the program counter, drives the byte address into `instruction_rom`, and captures the returned 32-bit word with its PC into a small prefetch buffer. It presents instructions to decode over a valid/ready handshake. Taken branches and jumps redirect it, flushing stale prefetched words. It sits between `instruction_rom` and the decode stage of the single-clock datapath.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- `DEPTH`, 2, prefetch buffer entries; power of two, ≥2
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rom_address`  out  32  byte address to `instruction_rom`; equals PC register
- `rom_instruction`  in  32  ROM word for `rom_address`, combinational, valid same cycle
- `redirect_valid`  in  1  taken branch/jump this cycle
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced 0)
- `halt`  in  1  level; suspend fetching while high
- `instr_valid`  out  1  buffer head holds an instruction
- `instr_ready`  in  1  decode accepts head this cycle
- `instr`  out  32  head instruction word; 0 when `instr_valid`=0
- `instr_pc`  out  32  PC of `instr`; 0 when `instr_valid`=0

## Operation
- Reset (async assert, sync release effect at next edge): PC=`RESET_PC`, buffer count=0, state=FETCH, `instr_valid`=0, `instr`=0, `instr_pc`=0, all entries zeroed.
- Pop: `instr_valid && instr_ready` at a rising edge; head advances.
- Push: in FETCH, no redirect, and (count<DEPTH or pop this cycle) → write {PC, `rom_instruction`} at tail, PC←PC+4.
- PC changes only on push or redirect; otherwise holds, `rom_address` stable.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Redirect (highest priority): a pop in the same cycle completes; all remaining entries are discarded (count←0). PC←{`redirect_target`[31:2],2'b00}. No push that cycle.
- FSM states:
  - FETCH → HALTED when `halt`=1 (no push that cycle).
  - HALTED → FETCH when `halt`=0.
  - HALTED: no pushes; buffer still drains via pops. Redirect updates PC and flushes; state stays HALTED.
- Full (count=DEPTH) with no pop: no push, PC held. Full with pop: push and pop both occur, count unchanged.
- Empty with push: the entry becomes visible next cycle. There is no bypass from ROM to `instr`.
- Reset asserted mid-operation: immediate return to reset values; in-flight entries are lost.

## Timing
- All state updates on the rising edge of `clk`. `instr`/`instr_pc`/`instr_valid` are driven from registers only. `instr_ready` affects only the push enable, not the outputs, in the same cycle.
- First edge after reset release: push `RESET_PC` word; `instr_valid`=1 from the following cycle.
- Redirect at edge N: target word pushed at edge N+1; `instr_valid`=1 after N+1. This is a one-cycle bubble.
- Steady state with `instr_ready`=1: one instruction per cycle, consecutive PCs +4.
- `halt` deassert at edge N: first push at edge N+1.

## Structure
- `fetch_pkg`: `fetch_state_t` enum {FETCH, HALTED}; constants `XLEN`=32 and `INSTR_BYTES`=4; typedef `fetch_entry_t` struct {pc, instr}.
- One sub-module: `fetch_fifo`, a synchronous FIFO parameterized by DEPTH and storing `fetch_entry_t`, with push, pop, flush, count, full, empty. Flush has priority over push; a same-cycle pop is honoured.
- The top level holds the PC register, the FSM, and push/redirect control.

## Test plan
- Reset release, `RESET_PC`=0, `instr_ready`=1, ROM word = address ^ 32'hA5A5_A5A5 → `instr_pc` 0,4,8,… on consecutive cycles after a one-cycle latency; `instr` matches.
- `instr_ready`=0 for 5 cycles → count saturates at 2; PC=8 and held; `rom_address` constant. Then ready=1 → entries for PCs 0,4,8 delivered in order with no gap.
- Redirect to 32'h0000_0103 while 2 entries are buffered and a pop is in progress → popped entry is consumed; rest discarded; next `instr_pc`=32'h0000_0100 after a one-cycle bubble.
- `halt`=1 with 2 buffered entries, ready=1 → both drain, then `instr_valid`=0, PC frozen. Redirect to 0x40 while halted → stays idle. `halt`=0 → 0x40 delivered.
- `RESET_PC`=32'hFFFF_FFF8, ready=1 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst_n` pulsed low mid-stream between edges → outputs go to 0 immediately. After release, fetch restarts at `RESET_PC`.
